mash_dwa_encoder: RTL
=====================

MASH_DWA_ENCODER -- requirements
Module: mash_dwa_encoder

Interface
REQ-001 SHALL have parameter DAC_BW, default 3, width of the signed MASH code input.
REQ-002 SHALL have parameter NUM_ELEM, default 3, number of unit DAC elements.
REQ-003 SHALL have parameter OFFSET, default 1, added to the code to form the element count n.
REQ-004 SHALL have port aclk  in  1  clock.
REQ-005 SHALL have port arst_n  in  1  reset, synchronous, active-low, sampled on aclk.
REQ-006 SHALL have port s_axis_data_tdata  in  DAC_BW  signed MASH code.
REQ-007 SHALL have port s_axis_data_tvalid  in  1  code valid.
REQ-008 SHALL have port s_axis_data_tready  out  1  constant 1.
REQ-009 SHALL have port dem_en  in  1  1 = data-weighted averaging, 0 = static thermometer.
REQ-010 SHALL have port clip_clear  in  1  clears clip_count.
REQ-011 SHALL have port m_elem  out  NUM_ELEM  registered unit-element drive.
REQ-012 SHALL have port m_elem_valid  out  1  one-cycle pulse per accepted code.
REQ-013 SHALL have port clip_count  out  16  saturating count of clamped codes.

Function
REQ-014 SHALL accept a code on each aclk edge with s_axis_data_tvalid=1; acceptance never stalls.
REQ-015 SHALL form n = code + OFFSET as a signed value at least DAC_BW+1 bits wide, clamped to 0..NUM_ELEM.
REQ-016 SHALL increment clip_count, saturating at 65535, when an accepted code needs clamping (n<0 or n>NUM_ELEM).
REQ-017 SHALL clear clip_count to 0 when clip_clear=1; a clear and a clip in the same cycle give 0.
REQ-018 SHALL, with dem_en=0, drive m_elem bits [n-1:0] high and the rest low, and force pointer p to 0.
REQ-019 SHALL, with dem_en=1, drive high the n bits at positions p, p+1, ... p+n-1 mod NUM_ELEM, and update p <= (p+n) mod NUM_ELEM.
REQ-020 SHALL make p width $clog2(NUM_ELEM), with p always within 0..NUM_ELEM-1.
REQ-021 SHALL leave p unchanged for n=0 (all off) and n=NUM_ELEM (all on).
REQ-022 SHALL update m_elem, p and m_elem_valid on the edge that accepts the code: latency 1 cycle.
REQ-023 SHALL hold m_elem and p, and drive m_elem_valid=0, in cycles with no valid code.
REQ-024 SHALL sample dem_en with each accepted code; a change takes effect on the next accepted code.

Reset
REQ-025 SHALL, while arst_n=0 at an aclk edge, set m_elem=0, p=0, m_elem_valid=0 and clip_count=0.
REQ-026 SHALL, on reset mid-stream, discard the code presented in that cycle.
REQ-027 SHALL, on release of reset, start DWA at p=0.

Structure
REQ-028 SHALL take the following from shared package dac_pkg: DAC_BW, NUM_ELEM and OFFSET defaults, and the clip counter width (16).
REQ-029 SHALL instantiate one combinational sub-module therm_rotate (inputs n and p, output NUM_ELEM-bit mask) used in both modes.
REQ-030 SHALL register all outputs, with no combinational path from input ports to output ports except s_axis_data_tready.

Verification
REQ-031 SHALL cover static mapping: dem_en=0, codes -1,0,1,2 -> m_elem 000,001,011,111, each one cycle after acceptance.
REQ-032 SHALL cover DWA sequencing: dem_en=1 from reset, codes 0,0,0,1 -> m_elem 001,010,100,011, with p = 1,2,0,2.
REQ-033 SHALL cover wrap-around: p=2, code 1 (n=2) -> m_elem 101, p=1.
REQ-034 SHALL cover clamping: code -4 -> m_elem 000 and clip_count+1; code 3 -> m_elem 111 and clip_count+1; saturation held at 65535; clip_clear coincident with a clip -> 0.
REQ-035 SHALL cover gaps: tvalid low for 5 cycles -> m_elem and p held, m_elem_valid=0 throughout.
REQ-036 SHALL cover reset mid-operation: arst_n=0 for one cycle at p=2 with a valid code -> m_elem=000, p=0, clip_count=0, m_elem_valid=0, and the code discarded.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared DAC encoder defaults.
// Holds the default MASH code width, element count, code offset and the width of the clip
// counter, so every block of the DAC path agrees on them.
package dac_pkg;

  localparam int DacBwDef   = 3;
  localparam int NumElemDef = 3;
  localparam int OffsetDef  = 1;
  localparam int ClipCntW   = 16;

endpackage

// File: rtl/therm_rotate.sv
// Rotated thermometer mask generator (combinational).
// Ports:
//   n_i    - number of elements to switch on, 0..NUM_ELEM
//   p_i    - index of the first element to switch on, 0..NUM_ELEM-1
//   mask_o - NUM_ELEM-bit mask with bits p, p+1, ... p+n-1 (mod NUM_ELEM) set
module therm_rotate #(
  parameter int NUM_ELEM = 3,
  parameter int CW       = 2,
  parameter int PW       = 2
) (
  input  logic [CW-1:0]       n_i,
  input  logic [PW-1:0]       p_i,
  output logic [NUM_ELEM-1:0] mask_o
);

  always_comb begin
    int idx;
    idx    = 0;
    mask_o = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      // Distance of element i from the pointer, walking forward with wrap.
      if (i >= int'(p_i)) begin
        idx = i - int'(p_i);
      end else begin
        idx = i - int'(p_i) + NUM_ELEM;
      end
      mask_o[i] = (idx < int'(n_i));
    end
  end

endmodule

// File: rtl/mash_dwa_encoder.sv
// MASH code to unit-element DAC encoder with optional data-weighted averaging.
// Ports:
//   aclk, arst_n        - clock and synchronous active-low reset
//   s_axis_data_tdata   - signed MASH code, accepted whenever tvalid is high
//   s_axis_data_tvalid  - code valid
//   s_axis_data_tready  - always 1, the encoder never stalls
//   dem_en              - 1: rotate elements (DWA), 0: static thermometer
//   clip_clear          - clears clip_count (wins over a coincident clip)
//   m_elem              - registered unit-element drive
//   m_elem_valid        - one-cycle pulse per accepted code
//   clip_count          - saturating count of codes that needed clamping
module mash_dwa_encoder
  import dac_pkg::*;
#(
  parameter int DAC_BW   = DacBwDef,
  parameter int NUM_ELEM = NumElemDef,
  parameter int OFFSET   = OffsetDef
) (
  input  logic                     aclk,
  input  logic                     arst_n,
  input  logic signed [DAC_BW-1:0] s_axis_data_tdata,
  input  logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tready,
  input  logic                     dem_en,
  input  logic                     clip_clear,
  output logic [NUM_ELEM-1:0]      m_elem,
  output logic                     m_elem_valid,
  output logic [ClipCntW-1:0]      clip_count
);

  localparam int CW = $clog2(NUM_ELEM + 1);
  localparam int PW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  logic [NUM_ELEM-1:0] m_elem_q, m_elem_d;
  logic                m_elem_valid_q, m_elem_valid_d;
  logic [ClipCntW-1:0] clip_count_q, clip_count_d;
  logic [PW-1:0]       p_q, p_d;

  int                  n_raw;
  int                  p_sum;
  logic [CW-1:0]       n_clamp;
  logic                clip;
  logic [PW-1:0]       p_use;
  logic [NUM_ELEM-1:0] mask;

  assign s_axis_data_tready = 1'b1;

  // 32-bit signed arithmetic comfortably covers code + OFFSET without overflow.
  always_comb begin
    n_raw   = int'(s_axis_data_tdata) + OFFSET;
    n_clamp = '0;
    clip    = 1'b0;
    if (n_raw < 0) begin
      clip = 1'b1;
    end else if (n_raw > NUM_ELEM) begin
      n_clamp = CW'(NUM_ELEM);
      clip    = 1'b1;
    end else begin
      n_clamp = CW'(n_raw);
    end
  end

  // Static mode is the rotator with the pointer pinned at zero.
  assign p_use = dem_en ? p_q : '0;

  therm_rotate #(
    .NUM_ELEM (NUM_ELEM),
    .CW       (CW),
    .PW       (PW)
  ) u_therm_rotate (
    .n_i    (n_clamp),
    .p_i    (p_use),
    .mask_o (mask)
  );

  always_comb begin
    m_elem_d       = m_elem_q;
    m_elem_valid_d = 1'b0;
    p_d            = p_q;
    clip_count_d   = clip_count_q;
    p_sum          = int'(p_q) + int'(n_clamp);

    if (s_axis_data_tvalid) begin
      m_elem_d       = mask;
      m_elem_valid_d = 1'b1;
      if (dem_en) begin
        // n <= NUM_ELEM and p < NUM_ELEM, so one subtraction wraps; n=0 and n=NUM_ELEM
        // both leave p where it was.
        if (p_sum >= NUM_ELEM) begin
          p_sum = p_sum - NUM_ELEM;
        end
        p_d = PW'(p_sum);
      end else begin
        p_d = '0;
      end
      if (clip && (clip_count_q != '1)) begin
        clip_count_d = clip_count_q + 1'b1;
      end
    end

    if (clip_clear) begin
      clip_count_d = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      m_elem_q       <= '0;
      m_elem_valid_q <= 1'b0;
      p_q            <= '0;
      clip_count_q   <= '0;
    end else begin
      m_elem_q       <= m_elem_d;
      m_elem_valid_q <= m_elem_valid_d;
      p_q            <= p_d;
      clip_count_q   <= clip_count_d;
    end
  end

  assign m_elem       = m_elem_q;
  assign m_elem_valid = m_elem_valid_q;
  assign clip_count   = clip_count_q;

endmodule
